// File: rtl/spi_master_if.sv
// Host and pin bundle for spi_master: start/tx_data/busy/done/rx_data plus the LOAD/SCLK/MOSI/MISO
// pins. The master modport is the controller's view; the slave modport is the driving side's view.
interface spi_master_if #(
   parameter int unsigned DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rx_data;
   logic              LOAD;
   logic              SCLK;
   logic              MOSI;
   logic              MISO;

   modport master (
      input  start, tx_data, MISO,
      output busy, done, rx_data, LOAD, SCLK, MOSI
   );

   modport slave (
      output start, tx_data, MISO,
      input  busy, done, rx_data, LOAD, SCLK, MOSI
   );
endinterface

// File: rtl/spi_master.sv
// System-clocked, MSB-first, full-duplex SPI master for the 8-bit LOAD/SCLK slave.
// Optional feature macro: SPI_MASTER_LOOPBACK_EN adds a loopback input that samples MOSI instead of MISO.
module spi_master #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CLK_DIV = 4
) (
   input logic          clk,
   input logic          rst,
   spi_master_if.master bus
`ifdef SPI_MASTER_LOOPBACK_EN
   ,
   input logic          loopback
`endif
);

   localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLdLo  = 3'd1;
   localparam logic [2:0] StLdHi  = 3'd2;
   localparam logic [2:0] StBitLo = 3'd3;
   localparam logic [2:0] StBitHi = 3'd4;
   localparam logic [2:0] StEndLd = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              load_q, load_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              phase_end;
   logic              rx_bit;

   assign phase_end = (cnt_q == CntW'(CLK_DIV - 1));

`ifdef SPI_MASTER_LOOPBACK_EN
   assign rx_bit = loopback ? mosi_q : bus.MISO;
`else
   assign rx_bit = bus.MISO;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      bit_cnt_d = bit_cnt_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      load_d    = load_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;

      if (state_q != StIdle && !phase_end) begin
         cnt_d = cnt_q + CntW'(1);
      end

      case (state_q)
         StIdle: begin
            if (bus.start) begin
               tx_sr_d   = bus.tx_data;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               load_d    = 1'b0;
               state_d   = StLdLo;
            end
         end
         StLdLo: begin
            if (phase_end) begin
               load_d  = 1'b1;
               state_d = StLdHi;
            end
         end
         StLdHi: begin
            if (phase_end) begin
               load_d  = 1'b0;
               mosi_d  = tx_sr_q[DATA_W-1];
               state_d = StBitLo;
            end
         end
         StBitLo: begin
            if (phase_end) begin
               sclk_d  = 1'b1;
               state_d = StBitHi;
            end
         end
         StBitHi: begin
            // Slave shifts MISO only on the SCLK fall, so the first high cycle is safe to sample.
            if (cnt_q == '0) begin
               rx_sr_d = {rx_sr_q[DATA_W-2:0], rx_bit};
            end
            if (phase_end) begin
               sclk_d  = 1'b0;
               tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
               if (bit_cnt_q == BitW'(DATA_W - 1)) begin
                  load_d  = 1'b1;
                  state_d = StEndLd;
               end else begin
                  mosi_d    = tx_sr_q[DATA_W-2];
                  bit_cnt_d = bit_cnt_q + BitW'(1);
                  state_d   = StBitLo;
               end
            end
         end
         StEndLd: begin
            // Stay here through the done cycle so a held start is taken one cycle later.
            if (done_q) begin
               state_d = StIdle;
            end else if (phase_end) begin
               rx_data_d = rx_sr_q;
               done_d    = 1'b1;
               busy_d    = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         load_q    <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         load_q    <= load_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;
   assign bus.LOAD    = load_q;
   assign bus.SCLK    = sclk_q;
   assign bus.MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1), each with a behavioural 8-bit slave;
// expected frames are queued at start and checked when done pulses.
module tb_spi_master;

   localparam int unsigned DW    = 8;
   localparam int unsigned LAT_A = (2 * DW + 3) * 2;
   localparam int unsigned LAT_B = (2 * DW + 3) * 1;

   typedef struct packed {
      logic [7:0]  rx;
      logic [7:0]  sdo;
      int unsigned lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_master_if #(.DATA_W(DW)) bus_a ();
   spi_master_if #(.DATA_W(DW)) bus_b ();

`ifdef SPI_MASTER_LOOPBACK_EN
   logic lb_a = 1'b0;
   logic lb_b = 1'b0;
`endif

   spi_master #(.DATA_W(DW), .CLK_DIV(2)) u_dut_a (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_a)
`ifdef SPI_MASTER_LOOPBACK_EN
      ,
      .loopback (lb_a)
`endif
   );

   spi_master #(.DATA_W(DW), .CLK_DIV(1)) u_dut_b (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_b)
`ifdef SPI_MASTER_LOOPBACK_EN
      ,
      .loopback (lb_b)
`endif
   );

   // Behavioural slaves: load DI / latch DO on LOAD rise, sample MOSI on SCLK rise, shift on fall.
   logic [7:0] sa_di = 8'h00, sa_out = 8'h00, sa_in = 8'h00, sa_do = 8'h00;
   logic [7:0] sb_di = 8'h00, sb_out = 8'h00, sb_in = 8'h00, sb_do = 8'h00;
   logic       miso_zero = 1'b0;

   always @(posedge bus_a.LOAD) begin sa_out <= sa_di; sa_do <= sa_in; end
   always @(posedge bus_a.SCLK) sa_in  <= {sa_in[6:0], bus_a.MOSI};
   always @(negedge bus_a.SCLK) sa_out <= {sa_out[6:0], 1'b0};
   assign bus_a.MISO = miso_zero ? 1'b0 : sa_out[7];

   always @(posedge bus_b.LOAD) begin sb_out <= sb_di; sb_do <= sb_in; end
   always @(posedge bus_b.SCLK) sb_in  <= {sb_in[6:0], bus_b.MOSI};
   always @(negedge bus_b.SCLK) sb_out <= {sb_out[6:0], 1'b0};
   assign bus_b.MISO = sb_out[7];

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   exp_t        q_a[$];
   exp_t        q_b[$];
   int unsigned cyc = 0;
   int unsigned acc_a = 0, acc_b = 0, done_at_a = 0, gap_a = 0;
   int unsigned rise_a = 0, rise_b = 0, hi_len_b = 0;
   int unsigned done_cnt_a = 0, done_cnt_b = 0;
   logic        busy_pa = 1'b0, sclk_pa = 1'b0, busy_pb = 1'b0, sclk_pb = 1'b0;

   // Monitor: samples on the falling clk edge, away from the DUT's active edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            busy_pa = 1'b0; sclk_pa = 1'b0; rise_a = 0;
            busy_pb = 1'b0; sclk_pb = 1'b0; rise_b = 0; hi_len_b = 0;
         end else begin
            if (bus_a.busy && !busy_pa) begin
               acc_a = cyc; gap_a = cyc - done_at_a; rise_a = 0;
            end
            if (bus_a.SCLK && !sclk_pa) begin
               rise_a++;
               check_eq("a_sclk_while_load", bus_a.LOAD, 0);
            end
            if (bus_a.done) begin
               done_at_a = cyc;
               done_cnt_a++;
               if (q_a.size() == 0) begin
                  check_eq("a_unexpected_done", bus_a.done, 0);
               end else begin
                  e = q_a.pop_front();
                  check_eq("a_rx_data", bus_a.rx_data, e.rx);
                  check_eq("a_slave_do", sa_do, e.sdo);
                  check_eq("a_latency", cyc - acc_a, e.lat);
                  check_eq("a_sclk_rises", rise_a, DW);
               end
            end
            busy_pa = bus_a.busy; sclk_pa = bus_a.SCLK;

            if (bus_b.busy && !busy_pb) begin acc_b = cyc; rise_b = 0; end
            if (bus_b.SCLK) hi_len_b++;
            if (bus_b.SCLK && !sclk_pb) begin
               rise_b++;
               check_eq("b_sclk_while_load", bus_b.LOAD, 0);
            end
            if (!bus_b.SCLK && sclk_pb) begin
               check_eq("b_sclk_high_len", hi_len_b, 1);
               hi_len_b = 0;
            end
            if (bus_b.done) begin
               done_cnt_b++;
               if (q_b.size() == 0) begin
                  check_eq("b_unexpected_done", bus_b.done, 0);
               end else begin
                  e = q_b.pop_front();
                  check_eq("b_rx_data", bus_b.rx_data, e.rx);
                  check_eq("b_slave_do", sb_do, e.sdo);
                  check_eq("b_latency", cyc - acc_b, e.lat);
                  check_eq("b_sclk_rises", rise_b, DW);
               end
            end
            busy_pb = bus_b.busy; sclk_pb = bus_b.SCLK;
         end
      end
   end

   task automatic send_a(input logic [7:0] tx, input logic [7:0] di, input logic [7:0] rx);
      @(negedge clk);
      sa_di = di;
      bus_a.tx_data = tx;
      bus_a.start = 1'b1;
      q_a.push_back('{rx: rx, sdo: tx, lat: LAT_A});
      @(negedge clk);
      bus_a.start = 1'b0;
      bus_a.tx_data = ~tx;
   endtask

   task automatic send_b(input logic [7:0] tx, input logic [7:0] di);
      @(negedge clk);
      sb_di = di;
      bus_b.tx_data = tx;
      bus_b.start = 1'b1;
      q_b.push_back('{rx: di, sdo: tx, lat: LAT_B});
      @(negedge clk);
      bus_b.start = 1'b0;
      bus_b.tx_data = ~tx;
   endtask

   task automatic wait_done_a(input int unsigned target);
      int unsigned n = 0;
      while (done_cnt_a < target && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
      check_eq("a_done_count", done_cnt_a, target);
   endtask

   task automatic wait_done_b(input int unsigned target);
      int unsigned n = 0;
      while (done_cnt_b < target && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      check_eq("b_done_count", done_cnt_b, target);
   endtask

   initial begin : stimulus
      int unsigned n;
      int unsigned dones;
      int unsigned base;
      rst = 1'b1;
      bus_a.start = 1'b0; bus_a.tx_data = '0;
      bus_b.start = 1'b0; bus_b.tx_data = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_load", bus_a.LOAD, 1);
      check_eq("rst_sclk", bus_a.SCLK, 0);
      check_eq("rst_mosi", bus_a.MOSI, 0);
      check_eq("rst_busy", bus_a.busy, 0);
      check_eq("rst_done", bus_a.done, 0);
      check_eq("rst_rx_data", bus_a.rx_data, 0);
      rst = 1'b0;

      // T1: CLK_DIV=2, A5 out, 3C in.
      send_a(8'hA5, 8'h3C, 8'h3C);
      wait_done_a(1);

      // T2: CLK_DIV=1, 00 and FF out, 81 in.
      send_b(8'h00, 8'h81);
      wait_done_b(1);
      send_b(8'hFF, 8'h81);
      wait_done_b(2);

      // T3: a start pulse mid-frame is ignored.
      send_a(8'hC7, 8'h5E, 8'h5E);
      repeat (3) @(negedge clk);
      bus_a.tx_data = 8'h11;
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      wait_done_a(2);
      repeat (10) @(negedge clk);
      check_eq("t3_single_done", done_cnt_a, 2);
      check_eq("t3_idle_busy", bus_a.busy, 0);

      // T4: start held high gives back-to-back frames one idle cycle apart.
      @(negedge clk);
      sa_di = 8'h24;
      bus_a.tx_data = 8'h5A;
      bus_a.start = 1'b1;
      q_a.push_back('{rx: 8'h24, sdo: 8'h5A, lat: LAT_A});
      n = 0;
      while (!bus_a.busy && n < 10) begin @(negedge clk); n++; end
      bus_a.tx_data = 8'hC3;
      q_a.push_back('{rx: 8'h24, sdo: 8'hC3, lat: LAT_A});
      dones = 0; n = 0;
      while (dones < 2 && n < 200) begin
         @(negedge clk); n++;
         if (bus_a.done) dones++;
      end
      bus_a.start = 1'b0;
      check_eq("t4_done_pulses", dones, 2);
      repeat (4) @(negedge clk);
      check_eq("t4_gap", gap_a, 2);
      check_eq("t4_no_third", bus_a.busy, 0);

      // T5: reset in the 3rd BIT_HI abandons the frame.
      send_a(8'h4E, 8'h99, 8'h99);
      n = 0;
      while (rise_a < 3 && n < 100) begin @(negedge clk); n++; end
      check_eq("t5_third_bit", rise_a, 3);
      rst = 1'b1;
      q_a.delete();
      base = done_cnt_a;
      @(negedge clk);
      check_eq("t5_load", bus_a.LOAD, 1);
      check_eq("t5_sclk", bus_a.SCLK, 0);
      check_eq("t5_mosi", bus_a.MOSI, 0);
      check_eq("t5_busy", bus_a.busy, 0);
      check_eq("t5_done", bus_a.done, 0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check_eq("t5_no_done", done_cnt_a, base);
      send_a(8'h96, 8'h5A, 8'h5A);
      wait_done_a(base + 1);

`ifdef SPI_MASTER_LOOPBACK_EN
      // T6: loopback ignores MISO and returns the transmitted byte.
      lb_a = 1'b1;
      miso_zero = 1'b1;
      send_a(8'h6B, 8'hFF, 8'h6B);
      wait_done_a(base + 2);
      lb_a = 1'b0;
      miso_zero = 1'b0;
`endif

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
